// File: rtl/tiny_cpu_core.sv
// Accumulator CPU core: fetches 8-bit instructions from a combinational ROM and emits bytes over valid/ready.
// Optional build macro TINY_CPU_ILLEGAL_TRAP_EN: opcodes 8-E halt the core instead of acting as NOP.
module tiny_cpu_core #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [7:0] RESET_ACC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] acc,
    output logic       halted
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WAIT_OUT,
        HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       halted_q, halted_d;

    logic [3:0] opcode;
    logic [7:0] imm;

    assign opcode = ir_q[7:4];
    assign imm    = {4'h0, ir_q[3:0]};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        ir_d        = ir_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;

        case (state_q)
            FETCH: begin
                ir_d    = rom_data;
                pc_d    = pc_q + 8'd1;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    4'h0: ;
                    4'h1: acc_d = imm;
                    4'h2: acc_d = acc_q + imm;
                    4'h3: acc_d = acc_q - imm;
                    4'h4: pc_d = imm;
                    4'h5: if (acc_q == 8'h00) pc_d = imm;
                    4'h6: begin
                        out_data_d  = imm;
                        out_valid_d = 1'b1;
                        state_d     = WAIT_OUT;
                    end
                    4'h7: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                        state_d     = WAIT_OUT;
                    end
                    4'hF: begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
`ifdef TINY_CPU_ILLEGAL_TRAP_EN
                    default: begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
`else
                    default: ;
`endif
                endcase
            end
            // out_data is deliberately left untouched after the transfer.
            WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            HALT: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            acc_q       <= RESET_ACC;
            ir_q        <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            ir_q        <= ir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign rom_addr  = pc_q;
    assign acc       = acc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;

endmodule
